// File: rtl/cam_manager_pkg.sv
// Shared encodings for the CAM command front end: response status, request op
// and controller state.
package cam_manager_pkg;

    typedef enum logic [1:0] {
        STATUS_OK        = 2'd0,
        STATUS_EXISTS    = 2'd1,
        STATUS_FULL      = 2'd2,
        STATUS_NOT_FOUND = 2'd3
    } status_t;

    typedef enum logic {
        OP_INSERT = 1'b0,
        OP_DELETE = 1'b1
    } op_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        WRITE     = 3'd2,
        WAIT_BUSY = 3'd3,
        RESP      = 3'd4
    } state_t;

    // Wide enough for MATCH_LATENCY up to 8.
    localparam int LOOKUP_CNT_W = 4;

endpackage

// File: rtl/cam_manager_priority_encoder.sv
// Generic priority encoder: index of the winning set bit plus an any-set flag.
// LSB_HIGH_PRIORITY selects whether the lowest or highest index wins.
module priority_encoder #(
    parameter int WIDTH             = 32,
    parameter bit LSB_HIGH_PRIORITY = 1'b1,
    localparam int IDX_W            = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan toward the winning end so the last hit written is the winner.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        if (LSB_HIGH_PRIORITY) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (req[i]) begin
                    idx   = IDX_W'(i);
                    valid = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (req[i]) begin
                    idx   = IDX_W'(i);
                    valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cam_manager.sv
// Key-based insert/delete front end that owns the CAM write port, looks keys up
// through the compare port and allocates the lowest free slot on insert.
module cam_manager
    import cam_manager_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDR_WIDTH    = 5,
    parameter int MATCH_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic                  req_op,
    input  logic                  req_valid,
    output logic                  req_ready,
    output logic [ADDR_WIDTH-1:0] resp_addr,
    output logic [1:0]            resp_status,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ADDR_WIDTH-1:0] cam_write_addr,
    output logic [DATA_WIDTH-1:0] cam_write_data,
    output logic                  cam_write_delete,
    output logic                  cam_write_enable,
    input  logic                  cam_write_busy,
    output logic [DATA_WIDTH-1:0] cam_compare_data,
    input  logic                  cam_match,
    input  logic [ADDR_WIDTH-1:0] cam_match_addr,
    output logic [ADDR_WIDTH:0]   free_count
);

    localparam int NUM_SLOTS = 1 << ADDR_WIDTH;

    state_t                  state, state_nxt;
    logic [DATA_WIDTH-1:0]   key_q;
    op_t                     op_q;
    logic [LOOKUP_CNT_W-1:0] lk_cnt;
    logic [NUM_SLOTS-1:0]    bitmap;
    logic [ADDR_WIDTH-1:0]   free_idx;
    logic                    free_vld;
    status_t                 status_q;
    logic                    req_hs;
    logic                    lookup_last;
    logic                    dec_write;
    logic                    dec_delete;
    logic [ADDR_WIDTH-1:0]   dec_addr;
    status_t                 dec_status;

    priority_encoder #(
        .WIDTH             (NUM_SLOTS),
        .LSB_HIGH_PRIORITY (1'b1)
    ) u_free_enc (
        .req   (~bitmap),
        .idx   (free_idx),
        .valid (free_vld)
    );

    assign req_hs           = req_valid && req_ready;
    assign lookup_last      = (state == LOOKUP) && (lk_cnt == '0);
    assign cam_compare_data = key_q;
    assign cam_write_data   = key_q;
    assign resp_status      = status_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic. WAIT_BUSY checks busy every cycle, so an idle CAM
    // costs exactly one cycle there.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (req_hs)          state_nxt = LOOKUP;
            LOOKUP:    if (lookup_last)     state_nxt = dec_write ? WRITE : RESP;
            WRITE:                          state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (!cam_write_busy) state_nxt = RESP;
            RESP:      if (resp_ready)      state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready        = rst_n && (state == IDLE) && !cam_write_busy;
        resp_valid       = (state == RESP);
        cam_write_enable = (state == WRITE);
    end

    // Decision from the match result sampled in the last LOOKUP cycle.
    always_comb begin
        dec_write  = 1'b0;
        dec_delete = 1'b0;
        dec_addr   = '0;
        dec_status = STATUS_OK;
        if (op_q == OP_INSERT) begin
            if (cam_match) begin
                dec_status = STATUS_EXISTS;
                dec_addr   = cam_match_addr;
            end else if (free_count == '0 || !free_vld) begin
                dec_status = STATUS_FULL;
            end else begin
                dec_write = 1'b1;
                dec_addr  = free_idx;
            end
        end else if (cam_match) begin
            dec_write  = 1'b1;
            dec_delete = 1'b1;
            dec_addr   = cam_match_addr;
        end else begin
            dec_status = STATUS_NOT_FOUND;
        end
    end

    // Key/op capture, lookup timer and registered decision outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q            <= '0;
            op_q             <= OP_INSERT;
            lk_cnt           <= '0;
            cam_write_addr   <= '0;
            cam_write_delete <= 1'b0;
            resp_addr        <= '0;
            status_q         <= STATUS_OK;
        end else begin
            if (req_hs) begin
                key_q  <= req_data;
                op_q   <= op_t'(req_op);
                lk_cnt <= LOOKUP_CNT_W'(MATCH_LATENCY);
            end else if (state == LOOKUP && lk_cnt != '0) begin
                lk_cnt <= lk_cnt - LOOKUP_CNT_W'(1);
            end
            if (lookup_last) begin
                cam_write_addr   <= dec_addr;
                cam_write_delete <= dec_delete;
                resp_addr        <= dec_addr;
                status_q         <= dec_status;
            end
        end
    end

    // Occupancy tracking; the counter moves with the bitmap so it never
    // needs a popcount.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitmap     <= '0;
            free_count <= {1'b1, {ADDR_WIDTH{1'b0}}};
        end else if (state == WRITE) begin
            bitmap[cam_write_addr] <= !cam_write_delete;
            free_count <= cam_write_delete ? free_count + (ADDR_WIDTH+1)'(1)
                                           : free_count - (ADDR_WIDTH+1)'(1);
        end
    end

endmodule

// File: tb/tb_cam_manager.sv
// Bench for cam_manager: a behavioural CAM on the compare/write ports, a
// slot-level reference model, table-driven directed vectors and random ops.
module tb_cam_manager;
    import cam_manager_pkg::*;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int NS = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] req_data;
    logic          req_op;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] resp_addr;
    logic [1:0]    resp_status;
    logic          resp_valid;
    logic          resp_ready;
    logic [AW-1:0] cam_write_addr;
    logic [DW-1:0] cam_write_data;
    logic          cam_write_delete;
    logic          cam_write_enable;
    logic          cam_write_busy;
    logic [DW-1:0] cam_compare_data;
    logic          cam_match;
    logic [AW-1:0] cam_match_addr;
    logic [AW:0]   free_count;

    cam_manager #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MATCH_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_data(req_data), .req_op(req_op),
        .req_valid(req_valid), .req_ready(req_ready), .resp_addr(resp_addr),
        .resp_status(resp_status), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .cam_write_addr(cam_write_addr), .cam_write_data(cam_write_data),
        .cam_write_delete(cam_write_delete), .cam_write_enable(cam_write_enable),
        .cam_write_busy(cam_write_busy), .cam_compare_data(cam_compare_data),
        .cam_match(cam_match), .cam_match_addr(cam_match_addr), .free_count(free_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural CAM: one-cycle registered match.
    logic [DW-1:0] cam_mem [NS];
    logic [NS-1:0] cam_v;
    logic          cam_hit;
    logic [AW-1:0] cam_hit_addr;

    always_comb begin
        cam_hit      = 1'b0;
        cam_hit_addr = '0;
        for (int i = 0; i < NS; i++)
            if (cam_v[i] && cam_mem[i] == cam_compare_data) begin
                cam_hit      = 1'b1;
                cam_hit_addr = AW'(i);
            end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cam_v          <= '0;
            cam_match      <= 1'b0;
            cam_match_addr <= '0;
        end else begin
            if (cam_write_enable) begin
                cam_v[cam_write_addr]   <= !cam_write_delete;
                cam_mem[cam_write_addr] <= cam_write_data;
            end
            cam_match      <= cam_hit;
            cam_match_addr <= cam_hit_addr;
        end
    end

    // Write-port monitor
    int            wr_cnt = 0;
    logic [AW-1:0] wr_addr_q;
    logic          wr_del_q;
    logic [DW-1:0] wr_data_q;
    always @(negedge clk) begin
        if (rst_n && cam_write_enable) begin
            wr_cnt    <= wr_cnt + 1;
            wr_addr_q <= cam_write_addr;
            wr_del_q  <= cam_write_delete;
            wr_data_q <= cam_write_data;
        end
    end

    // Reference model: which key lives in which slot.
    logic [DW-1:0] ref_key [NS];
    bit            ref_occ [NS];

    function automatic int ref_free();
        int n = 0;
        for (int i = 0; i < NS; i++) if (!ref_occ[i]) n++;
        return n;
    endfunction

    task automatic ref_clear();
        for (int i = 0; i < NS; i++) ref_occ[i] = 0;
    endtask

    task automatic ref_apply(input logic op, input logic [DW-1:0] key,
                             output logic [1:0] st, output logic [AW-1:0] ad, output bit wr);
        int hit = -1;
        int fr  = -1;
        for (int i = 0; i < NS; i++) if (ref_occ[i] && ref_key[i] == key) hit = i;
        for (int i = NS - 1; i >= 0; i--) if (!ref_occ[i]) fr = i;
        wr = 0;
        ad = '0;
        if (op == OP_INSERT) begin
            if (hit >= 0)    begin st = STATUS_EXISTS; ad = AW'(hit); end
            else if (fr < 0) st = STATUS_FULL;
            else begin
                st = STATUS_OK; ad = AW'(fr); wr = 1;
                ref_occ[fr] = 1; ref_key[fr] = key;
            end
        end else begin
            if (hit >= 0) begin st = STATUS_OK; ad = AW'(hit); wr = 1; ref_occ[hit] = 0; end
            else          st = STATUS_NOT_FOUND;
        end
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // One request/response exchange; latency counted from the handshake cycle.
    task automatic do_req(input logic op, input logic [DW-1:0] key, input int hold,
                          output logic [1:0] st, output logic [AW-1:0] ad, output int lat);
        int n;
        int t0;
        bit stable;
        st  = 'x;
        ad  = 'x;
        lat = -1;
        resp_ready = (hold == 0);
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        if (!req_ready) begin fail_now("req_ready wait"); return; end
        req_valid = 1'b1;
        req_op    = op;
        req_data  = key;
        t0        = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        req_data  = ~key;
        n = 0;
        while (!resp_valid && n < 100) begin @(negedge clk); n++; end
        if (!resp_valid) begin fail_now("resp_valid wait"); resp_ready = 1'b1; return; end
        lat = cyc - t0;
        st  = resp_status;
        ad  = resp_addr;
        if (hold > 0) begin
            stable = 1;
            repeat (hold) begin
                @(negedge clk);
                if (!resp_valid || resp_status !== st || resp_addr !== ad || req_ready) stable = 0;
            end
            chk("resp held under backpressure", stable, 1);
            resp_ready = 1'b1;
        end
        @(negedge clk);
        chk("resp_valid after handshake", resp_valid, 0);
    endtask

    task automatic run_txn(input logic op, input logic [DW-1:0] key, input bit use_ref,
                           input logic [1:0] est_in, input logic [AW-1:0] eaddr_in,
                           input int elat_in, input int hold);
        logic [1:0]    rs, st, est;
        logic [AW-1:0] ra, ad, eaddr;
        bit            rw;
        int            w0, lat, elat;
        ref_apply(op, key, rs, ra, rw);
        est   = use_ref ? rs : est_in;
        eaddr = use_ref ? ra : eaddr_in;
        elat  = use_ref ? (rw ? 5 : 3) : elat_in;
        w0 = wr_cnt;
        do_req(op, key, hold, st, ad, lat);
        chk("resp_status", st, est);
        chk("resp_addr", ad, eaddr);
        chk("latency", lat, elat);
        chk("write pulses", wr_cnt - w0, (est == STATUS_OK) ? 1 : 0);
        if (est == STATUS_OK) begin
            chk("cam_write_addr", wr_addr_q, eaddr);
            chk("cam_write_delete", wr_del_q, op);
            chk("cam_write_data", wr_data_q, key);
        end
        chk("free_count", free_count, ref_free());
        chk("req_ready when idle", req_ready, 1);
    endtask

    typedef struct {
        logic          op;
        logic [DW-1:0] key;
        logic [1:0]    st;
        logic [AW-1:0] addr;
        int            lat;
        int            hold;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int  n;
        bit  seen;
        vecs[0] = '{OP_INSERT, 64'h1234, STATUS_OK,        5'd0, 5, 0};
        vecs[1] = '{OP_INSERT, 64'h1234, STATUS_EXISTS,    5'd0, 3, 0};
        vecs[2] = '{OP_DELETE, 64'hDEAD, STATUS_NOT_FOUND, 5'd0, 3, 0};
        vecs[3] = '{OP_INSERT, 64'h5678, STATUS_OK,        5'd1, 5, 0};
        vecs[4] = '{OP_DELETE, 64'h1234, STATUS_OK,        5'd0, 5, 0};
        vecs[5] = '{OP_INSERT, 64'h9999, STATUS_OK,        5'd0, 5, 0};
        // After 30 fill inserts the table is full; key 0x1003 sits in slot 5.
        vecs[6] = '{OP_INSERT, 64'hBEEF, STATUS_FULL,      5'd0, 3, 0};
        vecs[7] = '{OP_DELETE, 64'h1003, STATUS_OK,        5'd5, 5, 0};
        vecs[8] = '{OP_INSERT, 64'hCAFE, STATUS_OK,        5'd5, 5, 0};
        vecs[9] = '{OP_DELETE, 64'hDEAD, STATUS_NOT_FOUND, 5'd0, 3, 4};

        rst_n          = 1'b0;
        req_valid      = 1'b0;
        req_op         = 1'b0;
        req_data       = '0;
        resp_ready     = 1'b1;
        cam_write_busy = 1'b0;
        ref_clear();
        repeat (3) @(negedge clk);
        chk("reset req_ready", req_ready, 0);
        chk("reset resp_valid", resp_valid, 0);
        chk("reset free_count", free_count, 32);
        chk("reset cam_write_enable", cam_write_enable, 0);
        chk("reset cam_write_delete", cam_write_delete, 0);
        chk("reset cam_write_addr", cam_write_addr, 0);
        chk("reset cam_compare_data", cam_compare_data, 0);
        chk("reset resp_addr", resp_addr, 0);
        chk("reset resp_status", resp_status, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("req_ready after reset", req_ready, 1);

        for (int i = 0; i < 10; i++) begin
            if (i == 6)
                for (int k = 0; k < 30; k++)
                    run_txn(OP_INSERT, 64'h1000 + 64'(k), 0, STATUS_OK, AW'(k + 2), 5, 0);
            run_txn(vecs[i].op, vecs[i].key, 0, vecs[i].st, vecs[i].addr, vecs[i].lat, vecs[i].hold);
        end

        for (int i = 0; i < 60; i++)
            run_txn(1'($urandom_range(0, 1)), 64'h1000 + 64'($urandom_range(0, 39)),
                    1, STATUS_OK, '0, 0, 0);

        // Busy held for three cycles after the write pulse delays the response by three.
        fork
            run_txn(OP_DELETE, 64'hCAFE, 0, STATUS_OK, 5'd5, 8, 0);
            begin
                n = 0;
                while (!cam_write_enable && n < 50) begin @(negedge clk); n++; end
                @(negedge clk);
                cam_write_busy = 1'b1;
                repeat (3) @(negedge clk);
                cam_write_busy = 1'b0;
            end
        join

        // Reset in the middle of LOOKUP aborts the command.
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        if (!req_ready) fail_now("req_ready before reset abort");
        req_valid = 1'b1;
        req_op    = OP_INSERT;
        req_data  = 64'h7777;
        @(negedge clk);
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("abort req_ready in reset", req_ready, 0);
        chk("abort resp_valid in reset", resp_valid, 0);
        chk("abort free_count", free_count, 32);
        @(negedge clk);
        rst_n = 1'b1;
        ref_clear();
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid || cam_write_enable) seen = 1;
        end
        chk("no response after abort", seen, 0);
        run_txn(OP_INSERT, 64'h7777, 0, STATUS_OK, 5'd0, 5, 0);
        run_txn(OP_INSERT, 64'h8888, 0, STATUS_OK, 5'd1, 5, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
